// File: rtl/xpb_pkg.sv
// Shared constants and FSM encoding for the xpb reduction-table sequencer.
package xpb_pkg;
    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 5;
    localparam int XPB_W      = 1024;
    localparam int SEL_W      = $clog2(NUM_DIGITS);
    // Extra bits let NUM_DIGITS full-scale entries sum without overflow.
    localparam int ACC_W      = XPB_W + $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;
endpackage

// File: rtl/xpb_accum_sched.sv
// Walks the latched upper-segment digits through the shared xpb LUT port, one per cycle,
// and sums the registered responses into a single wide accumulator.
module xpb_accum_sched
    import xpb_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    output logic                          busy,
    output logic                          done,
    output logic [ACC_W-1:0]              acc_out,
    output logic [SEL_W-1:0]              lut_sel,
    output logic [DIGIT_W-1:0]            lut_digit,
    input  logic [XPB_W-1:0]              lut_data
);

    state_t                        state_reg, state_next;
    logic [SEL_W-1:0]              cnt_reg;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_reg;
    logic [XPB_W-1:0]              xpb_q_reg;
    logic                          valid_reg;
    logic [ACC_W-1:0]              acc_reg;
    logic                          done_reg;
    logic [SEL_W-1:0]              sel_hold_reg;
    logic [DIGIT_W-1:0]            digit_hold_reg;
    logic [DIGIT_W-1:0]            cur_digit;
    logic                          last_digit;

    assign cur_digit  = digits_reg[int'(cnt_reg)*DIGIT_W +: DIGIT_W];
    assign last_digit = (cnt_reg == SEL_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        lut_sel    = sel_hold_reg;
        lut_digit  = digit_hold_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                lut_sel   = cnt_reg;
                lut_digit = cur_digit;
                if (last_digit) state_next = DRAIN;
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            digits_reg     <= '0;
            xpb_q_reg      <= '0;
            valid_reg      <= 1'b0;
            acc_reg        <= '0;
            done_reg       <= 1'b0;
            sel_hold_reg   <= '0;
            digit_hold_reg <= '0;
        end else begin
            done_reg <= (state_reg == DRAIN);
            // The response captured in one cycle is added on the following edge.
            if (valid_reg) begin
                acc_reg <= acc_reg + ACC_W'(xpb_q_reg);
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        digits_reg <= digits_in;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                    end
                end
                ISSUE: begin
                    xpb_q_reg      <= lut_data;
                    valid_reg      <= 1'b1;
                    sel_hold_reg   <= cnt_reg;
                    digit_hold_reg <= cur_digit;
                    cnt_reg        <= last_digit ? '0 : cnt_reg + SEL_W'(1);
                end
                DRAIN: begin
                    valid_reg <= 1'b0;
                end
                default: begin
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign done    = done_reg;
    assign acc_out = acc_reg;

endmodule

// File: tb/tb_xpb_accum_sched.sv
// Directed and randomized checks of the xpb sequencer against an arithmetic sum-of-lookups model.
module tb_xpb_accum_sched;
    import xpb_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          start;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
    logic                          busy;
    logic                          done;
    logic [ACC_W-1:0]              acc_out;
    logic [SEL_W-1:0]              lut_sel;
    logic [DIGIT_W-1:0]            lut_digit;
    logic [XPB_W-1:0]              lut_data;
    logic                          ones_mode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (ones_mode) lut_data = '1;
        else           lut_data = XPB_W'((int'(lut_sel) + 1) * 1000 + int'(lut_digit));
    end

    xpb_accum_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .digits_in (digits_in),
        .busy      (busy),
        .done      (done),
        .acc_out   (acc_out),
        .lut_sel   (lut_sel),
        .lut_digit (lut_digit),
        .lut_data  (lut_data)
    );

    task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] model_sum(input logic [NUM_DIGITS*DIGIT_W-1:0] d, input logic ones);
        logic [ACC_W-1:0] s = '0;
        logic [XPB_W-1:0] all_ones = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ones) s = s + ACC_W'(all_ones);
            else      s = s + ACC_W'((i + 1) * 1000 + int'(d[i*DIGIT_W +: DIGIT_W]));
        end
        return s;
    endfunction

    // One full operation from start to done, checking every cycle; called aligned at a negedge.
    task automatic run_op(input string name, input logic [NUM_DIGITS*DIGIT_W-1:0] d, input bit scramble);
        logic [ACC_W-1:0] exp;
        exp = model_sum(d, ones_mode);
        digits_in = d;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            check({name, " busy_issue"}, ACC_W'(busy), ACC_W'(1));
            check({name, " lut_sel"}, ACC_W'(lut_sel), ACC_W'(k - 1));
            check({name, " lut_digit"}, ACC_W'(lut_digit), ACC_W'(d[(k-1)*DIGIT_W +: DIGIT_W]));
            if (scramble) digits_in = {$urandom, $urandom};
            if (k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
            @(negedge clk);
        end
        check({name, " drain_busy"}, ACC_W'({busy, done}), ACC_W'(2'b10));
        @(negedge clk);
        check({name, " done_cycle"}, ACC_W'({busy, done}), ACC_W'(2'b01));
        check({name, " acc"}, acc_out, exp);
        check({name, " sel_hold"}, ACC_W'(lut_sel), ACC_W'(NUM_DIGITS - 1));
        @(negedge clk);
        check({name, " after_done"}, ACC_W'({busy, done}), ACC_W'(2'b00));
        check({name, " acc_held"}, acc_out, exp);
        $display("op %s digits=%0h acc=%0h expected=%0h", name, d, acc_out, exp);
    endtask

    initial begin
        logic [NUM_DIGITS*DIGIT_W-1:0] d, d2;
        logic [ACC_W-1:0] exp1, exp2;
        int done_count;
        rst = 1'b1; start = 1'b0; digits_in = '0; ones_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", ACC_W'({busy, done, lut_sel, lut_digit}), ACC_W'(0));
        check("reset_acc", acc_out, '0);
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("reset_beats_start", ACC_W'(busy), ACC_W'(0));

        run_op("zeros", '0, 1'b0);
        check("zeros_sum_const", acc_out, ACC_W'(36000));

        for (int i = 0; i < NUM_DIGITS; i++) d[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(i + 1);
        run_op("ramp", d, 1'b0);
        check("ramp_sum_const", acc_out, ACC_W'(36036));

        // Back-to-back: start held for 20 cycles gives exactly two operations.
        d  = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        exp1 = model_sum(d, 1'b0);
        exp2 = model_sum(d2, 1'b0);
        digits_in = d; start = 1'b1; done_count = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) digits_in = d2;
            if (c == 20) start = 1'b0;
            if (done) done_count++;
            if (c == 10 || c == 20) begin
                check($sformatf("b2b done_c%0d", c), ACC_W'(done), ACC_W'(1));
                check($sformatf("b2b acc_c%0d", c), acc_out, (c == 10) ? exp1 : exp2);
            end
            if (c == 11) check("b2b restart_busy", ACC_W'({busy, acc_out == '0}), ACC_W'(2'b11));
        end
        check("b2b done_count", ACC_W'(done_count), ACC_W'(2));
        $display("op b2b done_count=%0d acc=%0h", done_count, acc_out);

        // Reset mid-operation.
        digits_in = {$urandom, $urandom}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy_done", ACC_W'({busy, done}), ACC_W'(0));
        check("midrst acc", acc_out, '0);
        check("midrst lut", ACC_W'({lut_sel, lut_digit}), ACC_W'(0));
        done_count = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) done_count++;
        end
        check("midrst no_done", ACC_W'(done_count), ACC_W'(0));
        $display("op midreset done_count=%0d", done_count);
        run_op("after_rst", {$urandom, $urandom}, 1'b0);

        // Full-scale entries exercise the accumulator's top bits.
        ones_mode = 1'b1;
        run_op("ones", {$urandom, $urandom}, 1'b0);
        check("ones_top_bits", ACC_W'(acc_out[ACC_W-1 -: 3]), ACC_W'(3'b111));
        check("ones_low_bits", ACC_W'(acc_out[2:0]), ACC_W'(3'b000));
        ones_mode = 1'b0;

        for (int r = 0; r < 4; r++) begin
            run_op($sformatf("rand%0d", r), {$urandom, $urandom}, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
